// File: rtl/red_iterativa_izq_der.sv
// MSB-first iterative magnitude check: a chain of N identical cells feeds one
// output flop, with Zout = 1 when A <= B and Zout = 0 when A > B.

module red_iterativa_izq_der_cell (
  input  logic [1:0] st_in,
  input  logic       a,
  input  logic       b,
  output logic [1:0] st_out
);
  // State is {g, l}: EQ = 00, LT = 01, GT = 10. 11 is unreachable and is treated as GT.
  localparam logic [1:0] ST_EQ = 2'b00;
  localparam logic [1:0] ST_LT = 2'b01;
  localparam logic [1:0] ST_GT = 2'b10;

  always_comb begin
    st_out = ST_GT;
    case (st_in)
      ST_EQ: begin
        if (a && !b)      st_out = ST_GT;
        else if (!a && b) st_out = ST_LT;
        else              st_out = ST_EQ;
      end
      ST_LT:   st_out = ST_LT;
      default: st_out = ST_GT;
    endcase
  end
endmodule

module red_iterativa_izq_der #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Zout
);
  logic [1:0] st [N:0];
  logic       zout_next;

  // The MSB cell is seeded with EQ; st[i] is the state leaving cell i.
  assign st[N] = 2'b00;

  for (genvar i = N - 1; i >= 0; i--) begin : g_cell
    red_iterativa_izq_der_cell u_cell (
      .st_in  (st[i+1]),
      .a      (A[i]),
      .b      (B[i]),
      .st_out (st[i])
    );
  end

  // Equivalent to NOT g of the last state: EQ and LT mean A <= B.
  assign zout_next = (st[0] == 2'b00) || (st[0] == 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Zout <= 1'b1;
    else     Zout <= zout_next;
  end
endmodule

// File: tb/tb_red_iterativa_izq_der.sv
// Self-checking bench for red_iterativa_izq_der at N=4 and N=8, against an
// arithmetic A <= B reference model.

module tb_red_iterativa_izq_der;
  logic       clk;
  logic       rst;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       zout4, zout8;

  int checks;
  int errors;
  logic [0:0] exp_q[$];

  red_iterativa_izq_der #(.N(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .A    (a4),
    .B    (b4),
    .Zout (zout4)
  );

  red_iterativa_izq_der #(.N(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .A    (a8),
    .B    (b8),
    .Zout (zout8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_le(input int unsigned x, input int unsigned y);
    return (x <= y) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive both DUTs at the falling edge, then check after the next rising edge.
  task automatic drive4(input logic [3:0] x, input logic [3:0] y, input string tag);
    @(negedge clk);
    a4 = x;
    b4 = y;
    @(posedge clk);
    #1;
    check(tag, {31'd0, zout4}, {31'd0, ref_le(x, y)});
  endtask

  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input string tag);
    @(negedge clk);
    a8 = x;
    b8 = y;
    exp_q.push_back(ref_le(x, y));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 32'd1, 32'd0);
    end else begin
      check(tag, {31'd0, zout8}, {31'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    logic [3:0] ra, rb;
    int waited;
    checks = 0;
    errors = 0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    // reset state, asserted with no clock edge required
    rst = 1'b1;
    #2;
    check("reset_z4", {31'd0, zout4}, 32'd1);
    check("reset_z8", {31'd0, zout8}, 32'd1);
    a4 = 4'd10; b4 = 4'd4;
    @(posedge clk); #1;
    check("reset_hold_edge", {31'd0, zout4}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // directed N=4 vectors
    drive4(4'b1010, 4'b0100, "msb_gt");
    @(posedge clk); #1;
    check("msb_gt_hold", {31'd0, zout4}, 32'd0);
    drive4(4'b0011, 4'b0100, "bit2_lt");
    drive4(4'b1000, 4'b0000, "msb_only_gt");
    drive4(4'b0000, 4'b0000, "all_equal");
    drive4(4'b0101, 4'b0100, "lsb_gt");
    drive4(4'b0100, 4'b0101, "lsb_lt");
    drive4(4'b1111, 4'b1111, "ones_equal");

    // inputs changing between edges must not reach Zout
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd0;
    #2;
    check("no_early_update", {31'd0, zout4}, 32'd1);
    @(posedge clk); #1;
    check("late_update", {31'd0, zout4}, 32'd0);

    // asynchronous reset mid-operation
    drive4(4'd10, 4'd4, "pre_reset");
    waited = 0;
    while (zout4 !== 1'b0 && waited < 5) begin
      @(posedge clk); #1;
      waited++;
    end
    check("pre_reset_settled", {31'd0, zout4}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", {31'd0, zout4}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("reset_held", {31'd0, zout4}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_before_edge", {31'd0, zout4}, 32'd1);
    @(posedge clk); #1;
    check("release_first_edge", {31'd0, zout4}, 32'd0);

    // randomized N=4 vectors
    for (int k = 0; k < 200; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      drive4(ra, rb, "rand4");
    end

    // N=8 directed corners
    drive8(8'd255, 8'd255, "n8_255_255");
    drive8(8'd128, 8'd127, "n8_128_127");
    drive8(8'd127, 8'd128, "n8_127_128");
    drive8(8'd0,   8'd255, "n8_0_255");
    drive8(8'd255, 8'd0,   "n8_255_0");

    // N=8 exhaustive sweep, visited in a randomized order of starting offsets
    begin
      int unsigned off;
      off = $urandom_range(0, 65535);
      for (int k = 0; k < 65536; k++) begin
        int unsigned v;
        v = (k + off) % 65536;
        drive8(v[15:8], v[7:0], "n8_sweep");
      end
    end
    check("n8_queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/red_iterativa_izq_der.md
# red_iterativa_izq_der

Iterative comparator network that scans two N-bit unsigned words A and B from the most significant bit to the least significant bit. The result is reported as a single flag: Zout = 1 when A ≤ B, and Zout = 0 when A > B. The block is a chain of N identical combinational cells, and a single output register closes it. It serves as a standalone magnitude-check leaf in the datapath.

## Interface
- N, default 4: width of A and B in bits; legal range N ≥ 1.
- clk  input  1  rising-edge clock; the only clock of the block.
- rst  input  1  asynchronous reset, active-high.
- A  input  N  unsigned operand A; bit N-1 is the MSB.
- B  input  N  unsigned operand B; bit N-1 is the MSB.
- Zout  output  1  registered result: 1 when A ≤ B, 0 when A > B.

## Operation
- Cell chain:
  - Cells are indexed i = N-1 down to 0, with cell N-1 first.
  - Each cell takes the incoming state, a[i] and b[i], and produces an outgoing state.
  - The MSB cell receives state EQ.
- State encoding, 2 bits (g, l):
  - EQ = 00: the bits are equal so far.
  - GT = 10: A > B has been decided.
  - LT = 01: A < B has been decided.
  - 11 is unused.
- Cell transition:
  - In EQ: a=1,b=0 → GT; a=0,b=1 → LT; a=b → EQ.
  - GT and LT propagate unchanged, ignoring a[i] and b[i]. The first differing bit from the MSB decides the result.
  - An incoming 11 is treated as GT and propagates as GT. It is unreachable from the EQ seed.
- Final decode: the next value of Zout is NOT g of the state leaving cell 0. So EQ and LT give 1, and GT gives 0.
- Cells are built with a generate loop of N instances of one cell module or function. There is no arithmetic subtractor or comparator operator.
- All operands are unsigned. There is no sign handling and no overflow condition.

## Timing
- The cell chain is purely combinational. It has N cell delays from the MSB inputs to the output flop D input.
- A and B are sampled at each rising edge of clk, and Zout updates at that same edge.
- Latency is 1 cycle: Zout reflects the A and B values present at the most recent rising edge.
- A and B changing between edges have no effect until the next edge. No input register or handshake is used, and the result is valid every cycle.
- Reset:
  - While rst = 1, Zout = 1 immediately and asynchronously, regardless of clk. This value is consistent with A = B = 0.
  - Reset asserted mid-operation forces Zout to 1 at once, and any in-flight comparison is discarded.
  - On deassertion, the first rising edge of clk with rst = 0 loads the comparison of the current A and B.
- rst = 1 at the same time as a clk edge: reset wins and Zout stays 1.
- Inputs must meet setup and hold around the rising edge of clk. X or Z on A or B is not a supported input.

## Test plan
- N=4, A=4'b1010 (10), B=4'b0100 (4), held for 2 clocks → Zout = 0 after the first edge. Exercises an MSB decision of GT.
- N=4, A=4'b0011 (3), B=4'b0100 (4) → Zout = 1. Exercises a bit-2 decision of LT, with later bits (a=1, b=0) ignored.
- N=4, A=4'b1000, B=4'b0000 → Zout = 0. Then A=4'b0000, B=4'b0000 → Zout = 1, covering the equal case across all cells.
- Late-decision check, N=4: A=4'b0101, B=4'b0100 → Zout = 0, decided at LSB only. Then A=4'b0100, B=4'b0101 → Zout = 1.
- Reset check:
  - Drive A=10, B=4 and clock until Zout = 0.
  - Assert rst between clock edges → Zout = 1 immediately, before the next edge.
  - Hold rst across 2 edges → Zout stays 1.
  - Release rst → Zout = 0 after the first subsequent edge.
- Parameter check, N=8, one vector per clock:
  - 255 vs 255 → 1.
  - 128 vs 127 → 0.
  - 127 vs 128 → 1.
  - 0 vs 255 → 1.
  - Exhaustive sweep of all 65536 pairs against a reference model: Zout = (A ≤ B), with the result one cycle late.
